// File: rtl/rvee_scoreboard.sv
// Register scoreboard for the RVee pipeline: a DEPTH-entry table of in-flight
// register writers with per-entry result-latency countdowns, queried by decode.
module rvee_scoreboard #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter int LAT_W = 3,
    parameter int TAG_W = $clog2(DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst_n,

    input  logic                         issue_valid,
    input  logic                         issue_rd_we,
    input  logic [4:0]                   issue_rd,
    input  logic [LAT_W-1:0]             issue_lat,
    output logic                         issue_ready,
    output logic                         issue_alloc,
    output logic [TAG_W-1:0]             issue_tag,

    input  logic [4:0]                   chk_rs1,
    input  logic [4:0]                   chk_rs2,
    input  logic                         chk_rs1_used,
    input  logic                         chk_rs2_used,
    output logic                         hazard,
    output logic                         fwd_rs1_hit,
    output logic                         fwd_rs2_hit,
    output logic [TAG_W-1:0]             fwd_rs1_tag,
    output logic [TAG_W-1:0]             fwd_rs2_tag,

    input  logic                         wb_valid,
    input  logic [TAG_W-1:0]             wb_tag,
    input  logic [DEPTH-1:0]             flush_mask,

    output logic [$clog2(DEPTH+1)-1:0]   occupancy,
    output logic                         err
);

    localparam int OCC_W = $clog2(DEPTH+1);

    // An out-of-range configuration never accepts new writers.
    localparam bit CFG_OK = (XLEN > 0) && (DEPTH >= 2) && (DEPTH <= 16) &&
                            (TAG_W == $clog2(DEPTH)) && (LAT_W >= 1);

    logic [DEPTH-1:0] v_q,   v_d;
    logic [4:0]       rd_q  [DEPTH];
    logic [4:0]       rd_d  [DEPTH];
    logic [LAT_W-1:0] cnt_q [DEPTH];
    logic [LAT_W-1:0] cnt_d [DEPTH];
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             err_q, err_d;

    logic             alloc_req;
    logic             full;
    logic             waw;
    logic             wb_hit;
    logic [TAG_W-1:0] free_tag;

    // Free-entry priority encode, WAW detection and retire-target validity.
    always_comb begin
        alloc_req = issue_valid && issue_rd_we && (issue_rd != 5'd0);
        full      = 1'b1;
        waw       = 1'b0;
        wb_hit    = 1'b0;
        free_tag  = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!v_q[i]) begin
                full     = 1'b0;
                free_tag = TAG_W'(i);
            end
            if (v_q[i] && (rd_q[i] == issue_rd)) begin
                waw = 1'b1;
            end
            if (v_q[i] && (wb_tag == TAG_W'(i))) begin
                wb_hit = 1'b1;
            end
        end
    end

    always_comb begin
        issue_ready = CFG_OK && !(alloc_req && (full || waw));
        issue_alloc = alloc_req && issue_ready;
        issue_tag   = free_tag;
    end

    // Operand queries see registered state only, never this cycle's allocation.
    always_comb begin
        hazard      = 1'b0;
        fwd_rs1_hit = 1'b0;
        fwd_rs2_hit = 1'b0;
        fwd_rs1_tag = '0;
        fwd_rs2_tag = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (v_q[i] && chk_rs1_used && (chk_rs1 != 5'd0) && (rd_q[i] == chk_rs1)) begin
                if (cnt_q[i] != '0) begin
                    hazard = 1'b1;
                end else begin
                    fwd_rs1_hit = 1'b1;
                    fwd_rs1_tag = TAG_W'(i);
                end
            end
            if (v_q[i] && chk_rs2_used && (chk_rs2 != 5'd0) && (rd_q[i] == chk_rs2)) begin
                if (cnt_q[i] != '0) begin
                    hazard = 1'b1;
                end else begin
                    fwd_rs2_hit = 1'b1;
                    fwd_rs2_tag = TAG_W'(i);
                end
            end
        end
    end

    // Per-entry next state: allocate > retire > flush > countdown.
    always_comb begin
        v_d   = v_q;
        occ_d = '0;
        err_d = err_q || (wb_valid && !wb_hit);
        for (int i = 0; i < DEPTH; i++) begin
            rd_d[i]  = rd_q[i];
            cnt_d[i] = (v_q[i] && (cnt_q[i] != '0)) ? (cnt_q[i] - LAT_W'(1)) : cnt_q[i];
            if (issue_alloc && (free_tag == TAG_W'(i))) begin
                v_d[i]   = 1'b1;
                rd_d[i]  = issue_rd;
                cnt_d[i] = issue_lat;
            end else if (wb_valid && (wb_tag == TAG_W'(i))) begin
                v_d[i] = 1'b0;
            end else if (flush_mask[i]) begin
                v_d[i] = 1'b0;
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            occ_d = occ_d + OCC_W'(v_d[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q   <= '0;
            occ_q <= '0;
            err_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i]  <= '0;
                cnt_q[i] <= '0;
            end
        end else begin
            v_q   <= v_d;
            occ_q <= occ_d;
            err_q <= err_d;
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i]  <= rd_d[i];
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign occupancy = occ_q;
    assign err       = err_q;

endmodule

// File: tb/tb_rvee_scoreboard.sv
// Directed bench for rvee_scoreboard (DEPTH=4): expected allocation tags are
// queued when an issue is driven and popped when the DUT presents issue_tag.
module tb_rvee_scoreboard;

    localparam int DEPTH = 4;
    localparam int LAT_W = 3;
    localparam int TAG_W = 2;

    logic             clk;
    logic             rst_n;
    logic             issue_valid;
    logic             issue_rd_we;
    logic [4:0]       issue_rd;
    logic [LAT_W-1:0] issue_lat;
    logic             issue_ready;
    logic             issue_alloc;
    logic [TAG_W-1:0] issue_tag;
    logic [4:0]       chk_rs1;
    logic [4:0]       chk_rs2;
    logic             chk_rs1_used;
    logic             chk_rs2_used;
    logic             hazard;
    logic             fwd_rs1_hit;
    logic             fwd_rs2_hit;
    logic [TAG_W-1:0] fwd_rs1_tag;
    logic [TAG_W-1:0] fwd_rs2_tag;
    logic             wb_valid;
    logic [TAG_W-1:0] wb_tag;
    logic [DEPTH-1:0] flush_mask;
    logic [2:0]       occupancy;
    logic             err;

    int total = 0;
    int bad   = 0;
    int exp_tag_q[$];

    rvee_scoreboard #(.XLEN(32), .DEPTH(DEPTH), .LAT_W(LAT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .issue_valid  (issue_valid),
        .issue_rd_we  (issue_rd_we),
        .issue_rd     (issue_rd),
        .issue_lat    (issue_lat),
        .issue_ready  (issue_ready),
        .issue_alloc  (issue_alloc),
        .issue_tag    (issue_tag),
        .chk_rs1      (chk_rs1),
        .chk_rs2      (chk_rs2),
        .chk_rs1_used (chk_rs1_used),
        .chk_rs2_used (chk_rs2_used),
        .hazard       (hazard),
        .fwd_rs1_hit  (fwd_rs1_hit),
        .fwd_rs2_hit  (fwd_rs2_hit),
        .fwd_rs1_tag  (fwd_rs1_tag),
        .fwd_rs2_tag  (fwd_rs2_tag),
        .wb_valid     (wb_valid),
        .wb_tag       (wb_tag),
        .flush_mask   (flush_mask),
        .occupancy    (occupancy),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", name, obs, exp);
        end
    endtask

    task automatic idle_in();
        issue_valid  = 1'b0;
        issue_rd_we  = 1'b0;
        issue_rd     = 5'd0;
        issue_lat    = 3'd0;
        chk_rs1      = 5'd0;
        chk_rs2      = 5'd0;
        chk_rs1_used = 1'b0;
        chk_rs2_used = 1'b0;
        wb_valid     = 1'b0;
        wb_tag       = 2'd0;
        flush_mask   = 4'b0000;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle_in();
    endtask

    task automatic issue(input logic [4:0] rd, input logic [LAT_W-1:0] lat, input int exp_tag);
        issue_valid = 1'b1;
        issue_rd_we = 1'b1;
        issue_rd    = rd;
        issue_lat   = lat;
        exp_tag_q.push_back(exp_tag);
    endtask

    task automatic chk_alloc(input string name);
        int t;
        #1;
        chk({name, "_alloc"}, 32'(issue_alloc), 1);
        if (exp_tag_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s_tag: observed=%0d expected=<empty queue>", name, issue_tag);
        end else begin
            t = exp_tag_q.pop_front();
            chk({name, "_tag"}, 32'(issue_tag), t);
        end
    endtask

    initial begin
        idle_in();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        // Live inputs while held in reset
        issue_valid = 1'b1; issue_rd_we = 1'b1; issue_rd = 5'd3;
        chk_rs1 = 5'd3; chk_rs1_used = 1'b1;
        #1;
        chk("rst_hazard", 32'(hazard), 0);
        chk("rst_ready", 32'(issue_ready), 1);
        chk("rst_fwd1", 32'(fwd_rs1_hit), 0);
        tick();
        chk("rst_occ", 32'(occupancy), 0);
        chk("rst_err", 32'(err), 0);
        rst_n = 1'b1;
        #1;
        chk("idle_hazard", 32'(hazard), 0);
        chk("idle_ready", 32'(issue_ready), 1);

        // x0 writer never allocates
        issue_valid = 1'b1; issue_rd_we = 1'b1; issue_rd = 5'd0;
        #1;
        chk("x0_alloc", 32'(issue_alloc), 0);
        chk("x0_ready", 32'(issue_ready), 1);
        tick();
        chk("x0_occ", 32'(occupancy), 0);

        // Latency countdown: rd=5, lat=2 issued at cycle 0
        issue(5'd5, 3'd2, 0);
        chk_rs1 = 5'd5; chk_rs1_used = 1'b1;
        chk_alloc("lat_iss");
        chk("lat_c0_haz", 32'(hazard), 0);
        tick();
        chk_rs1 = 5'd5; chk_rs2 = 5'd5; chk_rs2_used = 1'b1;
        #1;
        chk("lat_c1_haz_rs2", 32'(hazard), 1);
        chk("lat_c1_occ", 32'(occupancy), 1);
        tick();
        chk_rs1 = 5'd5; chk_rs1_used = 1'b1;
        #1;
        chk("lat_c2_haz", 32'(hazard), 1);
        chk("lat_c2_hit", 32'(fwd_rs1_hit), 0);
        tick();
        chk_rs1 = 5'd5; chk_rs1_used = 1'b1; chk_rs2 = 5'd5; chk_rs2_used = 1'b1;
        #1;
        chk("lat_c3_haz", 32'(hazard), 0);
        chk("lat_c3_hit1", 32'(fwd_rs1_hit), 1);
        chk("lat_c3_tag1", 32'(fwd_rs1_tag), 0);
        chk("lat_c3_hit2", 32'(fwd_rs2_hit), 1);
        tick();
        chk_rs1 = 5'd5; chk_rs1_used = 1'b1; wb_valid = 1'b1; wb_tag = 2'd0;
        #1;
        chk("lat_c4_hit", 32'(fwd_rs1_hit), 1);
        chk("lat_c4_haz", 32'(hazard), 0);
        tick();
        chk_rs1 = 5'd5; chk_rs1_used = 1'b1;
        #1;
        chk("lat_c5_hit", 32'(fwd_rs1_hit), 0);
        chk("lat_c5_occ", 32'(occupancy), 0);
        chk("lat_c5_err", 32'(err), 0);

        // Fill all four entries
        for (int i = 0; i < DEPTH; i++) begin
            tick();
            issue(5'(i + 1), 3'd0, i);
            chk_alloc("full_iss");
        end
        tick();
        chk("full_occ", 32'(occupancy), 4);
        issue_valid = 1'b1; issue_rd_we = 1'b1; issue_rd = 5'd6;
        chk_rs1 = 5'd3; chk_rs1_used = 1'b1;
        #1;
        chk("full_ready", 32'(issue_ready), 0);
        chk("full_alloc", 32'(issue_alloc), 0);
        chk("full_fwd_hit", 32'(fwd_rs1_hit), 1);
        chk("full_fwd_tag", 32'(fwd_rs1_tag), 2);
        tick();
        issue_valid = 1'b1; issue_rd_we = 1'b1; issue_rd = 5'd6;
        wb_valid = 1'b1; wb_tag = 2'd2;
        #1;
        chk("full_retire_ready", 32'(issue_ready), 0);
        tick();
        issue(5'd6, 3'd0, 2);
        chk_alloc("refill");
        tick();
        chk("refill_occ", 32'(occupancy), 4);
        chk("refill_err", 32'(err), 0);
        for (int i = 0; i < DEPTH; i++) begin
            wb_valid = 1'b1; wb_tag = 2'(i);
            tick();
        end
        chk("drain_occ", 32'(occupancy), 0);
        chk("drain_err", 32'(err), 0);

        // WAW stall on rd=7, independent rd=8 still accepted
        issue(5'd7, 3'd3, 0);
        chk_alloc("waw_first");
        tick();
        issue_valid = 1'b1; issue_rd_we = 1'b1; issue_rd = 5'd7;
        #1;
        chk("waw_ready", 32'(issue_ready), 0);
        chk("waw_alloc", 32'(issue_alloc), 0);
        tick();
        issue(5'd8, 3'd0, 1);
        chk_alloc("waw_other");
        tick();
        issue_valid = 1'b1; issue_rd_we = 1'b1; issue_rd = 5'd7;
        wb_valid = 1'b1; wb_tag = 2'd0;
        #1;
        chk("waw_retire_ready", 32'(issue_ready), 0);
        tick();
        issue(5'd7, 3'd1, 0);
        chk_alloc("waw_reissue");
        tick();
        chk("waw_occ", 32'(occupancy), 2);
        wb_valid = 1'b1; wb_tag = 2'd0;
        tick();
        wb_valid = 1'b1; wb_tag = 2'd1;
        tick();
        chk("waw_drain_occ", 32'(occupancy), 0);

        // Flush tags 1,2 while issuing into the lowest free tag (3)
        issue(5'd10, 3'd0, 0);
        chk_alloc("fl_a");
        tick();
        issue(5'd11, 3'd0, 1);
        chk_alloc("fl_b");
        tick();
        issue(5'd12, 3'd0, 2);
        chk_alloc("fl_c");
        tick();
        flush_mask = 4'b0110;
        issue(5'd13, 3'd0, 3);
        chk_alloc("fl_iss");
        tick();
        chk("fl_occ", 32'(occupancy), 2);
        chk_rs1 = 5'd11; chk_rs1_used = 1'b1;
        chk_rs2 = 5'd10; chk_rs2_used = 1'b1;
        issue(5'd14, 3'd0, 1);
        chk_alloc("fl_reuse");
        chk("fl_rs1_hit", 32'(fwd_rs1_hit), 0);
        chk("fl_haz", 32'(hazard), 0);
        chk("fl_rs2_hit", 32'(fwd_rs2_hit), 1);
        chk("fl_rs2_tag", 32'(fwd_rs2_tag), 0);
        tick();
        chk("fl_reuse_occ", 32'(occupancy), 3);

        // Retire of an invalid entry sets sticky err
        wb_valid = 1'b1; wb_tag = 2'd2;
        tick();
        chk("err_set", 32'(err), 1);
        chk("err_occ", 32'(occupancy), 3);
        tick();
        chk("err_sticky", 32'(err), 1);

        // Asynchronous reset between clock edges
        chk_rs2 = 5'd10; chk_rs2_used = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_err", 32'(err), 0);
        chk("arst_occ", 32'(occupancy), 0);
        chk("arst_fwd2", 32'(fwd_rs2_hit), 0);
        tick();
        rst_n = 1'b1;
        issue(5'd20, 3'd0, 0);
        chk_alloc("post_rst");
        tick();
        chk("post_rst_occ", 32'(occupancy), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
